// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared constants, FSM states and flattened-bus helpers for kmeans_iter_ctrl.
// Flattened buses are laid out as entry i = k*D+d, entry 0 in the least significant bits.
`ifndef KMEANS_PKG_SV
`define KMEANS_PKG_SV

`define KM_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package kmeans_pkg;
  localparam int K        = 2;
  localparam int D        = 3;
  localparam int NC       = K * D;
  localparam int PIPE_LAT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_UPDATE,
    ST_CHECK,
    ST_FIN
  } state_e;
endpackage

`endif

// File: rtl/kmeans_iter_ctrl_div.sv
// kmeans_div_seq: unsigned restoring divider, one quotient bit per cycle, start/busy/done handshake.
// The divisor must be non-zero; only the low quotient_width quotient bits are exported.
module kmeans_div_seq #(
  parameter int dividend_width = 27,
  parameter int divisor_width  = 11,
  parameter int quotient_width = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      busy,
  output logic                      done,
  output logic [quotient_width-1:0] quotient
);
  localparam int CNTW = $clog2(dividend_width + 1);

  logic                      busy_q, busy_d, done_q, done_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [divisor_width-1:0]  rem_q, rem_d, dvs_q, dvs_d;
  logic [dividend_width-1:0] quo_q, quo_d;
  logic [divisor_width:0]    shifted, diff;

  // The remainder stays below the divisor, so one extra bit is enough for the trial subtract.
  assign shifted = {rem_q, quo_q[dividend_width-1]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        cnt_d  = CNTW'(dividend_width);
        rem_d  = '0;
        quo_d  = dividend;
        dvs_d  = divisor;
      end
    end else begin
      if (!diff[divisor_width]) begin
        rem_d = diff[divisor_width-1:0];
        quo_d = {quo_q[dividend_width-2:0], 1'b1};
      end else begin
        rem_d = shifted[divisor_width-1:0];
        quo_d = {quo_q[dividend_width-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNTW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q[quotient_width-1:0];
endmodule

// File: rtl/kmeans_iter_ctrl.sv
// kmeans_iter_ctrl: K=2, D=3 k-means sequencer streaming a point memory through kmeans_pipeline_k2_d3.
// Define KMEANS_CTRL_CONVERGE_EN to end a run early once a pass leaves every centroid unchanged.
module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter int input_data_width = 16,
  parameter int addr_width       = 10,
  parameter int iter_width       = 8,
  parameter int pipe_latency     = PIPE_LAT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [addr_width:0]           n_points,
  input  logic [iter_width-1:0]         max_iter,
  input  logic                          cfg_we,
  input  logic [2:0]                    cfg_idx,
  input  logic [input_data_width-1:0]   cfg_data,
  output logic                          mem_rd_en,
  output logic [addr_width-1:0]         mem_rd_addr,
  input  logic [3*input_data_width-1:0] mem_rd_data,
  output logic [6*input_data_width-1:0] pipe_centroids,
  output logic [3*input_data_width-1:0] pipe_data,
  input  logic                          pipe_sel,
  input  logic [3*input_data_width-1:0] pipe_out_data,
  output logic                          busy,
  output logic                          done,
  output logic [iter_width-1:0]         iter_count
);
  localparam int W  = input_data_width;
  localparam int AW = addr_width;
  localparam int IW = iter_width;
  localparam int SW = W + AW + 1;
  localparam int CW = AW + 1;
`ifdef KMEANS_CTRL_CONVERGE_EN
  localparam bit CONVERGE_EN = 1'b1;
`else
  localparam bit CONVERGE_EN = 1'b0;
`endif

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
  logic                   div_pend_q, div_pend_d, changed_q, changed_d;
  logic [AW:0]            rd_cnt_q, rd_cnt_d, n_q, n_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic [IW-1:0]          iter_q, iter_d, maxi_q, maxi_d, iter_inc;
  logic [pipe_latency:0]  vld_q, vld_d;
  logic [2:0]             upd_idx_q, upd_idx_d;
  logic [NC-1:0][W-1:0]   cent_q, cent_d;
  logic [NC-1:0][SW-1:0]  sum_q, sum_d;
  logic [K-1:0][CW-1:0]   cnt_q, cnt_d;
  logic                   upd_k, adv, div_start, div_busy, div_done, conv_stop;
  logic [W-1:0]           div_quo;

  assign upd_k     = (upd_idx_q >= 3'(D));
  assign iter_inc  = iter_q + 1'b1;
  assign conv_stop = CONVERGE_EN && !changed_q;

  kmeans_div_seq #(
    .dividend_width(SW),
    .divisor_width (CW),
    .quotient_width(W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(sum_q[upd_idx_q]),
    .divisor (cnt_q[upd_k]),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_quo)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = rd_addr_q;
    n_d        = n_q;
    iter_d     = iter_q;
    maxi_d     = maxi_q;
    upd_idx_d  = upd_idx_q;
    div_pend_d = div_pend_q;
    changed_d  = changed_q;
    cent_d     = cent_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    div_start  = 1'b0;
    adv        = 1'b0;
    // vld_q[0] marks a cycle where mem_rd_data holds a sample; vld_q[pipe_latency] its pipeline result.
    vld_d      = {vld_q[pipe_latency-1:0], rd_en_q};

    if (vld_q[pipe_latency]) begin
      cnt_d[pipe_sel] = cnt_q[pipe_sel] + 1'b1;
      for (int d = 0; d < D; d++) begin
        sum_d[int'(pipe_sel)*D + d] = sum_q[int'(pipe_sel)*D + d] + SW'(`KM_SLICE(pipe_out_data, d, W));
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_we && (cfg_idx < 3'(NC))) cent_d[cfg_idx] = cfg_data;
        if (start) begin
          iter_d = '0;
          n_d    = n_points;
          maxi_d = max_iter;
          if (max_iter == '0) begin
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            busy_d    = 1'b1;
            sum_d     = '0;
            cnt_d     = '0;
            rd_cnt_d  = '0;
            changed_d = 1'b0;
            state_d   = ST_STREAM;
          end
        end
      end
      ST_STREAM: begin
        if (rd_cnt_q < n_q) begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_cnt_q[AW-1:0];
          rd_cnt_d  = rd_cnt_q + 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((vld_q == '0) && !rd_en_q) begin
          upd_idx_d  = '0;
          div_pend_d = 1'b0;
          state_d    = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (!div_pend_q) begin
          if (cnt_q[upd_k] == '0) begin
            adv = 1'b1;
          end else if (!div_busy) begin
            div_start  = 1'b1;
            div_pend_d = 1'b1;
          end
        end else if (div_done) begin
          cent_d[upd_idx_q] = div_quo;
          if (div_quo != cent_q[upd_idx_q]) changed_d = 1'b1;
          div_pend_d = 1'b0;
          adv        = 1'b1;
        end
        if (adv) begin
          if (upd_idx_q == 3'(NC - 1)) state_d = ST_CHECK;
          else upd_idx_d = upd_idx_q + 1'b1;
        end
      end
      ST_CHECK: begin
        iter_d = iter_inc;
        if ((iter_inc == maxi_q) || conv_stop) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else begin
          sum_d     = '0;
          cnt_d     = '0;
          rd_cnt_d  = '0;
          changed_d = 1'b0;
          state_d   = ST_STREAM;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: centroids and accumulators are plain flops, not RAM, so reset clears them like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      n_q        <= '0;
      iter_q     <= '0;
      maxi_q     <= '0;
      vld_q      <= '0;
      upd_idx_q  <= '0;
      div_pend_q <= 1'b0;
      changed_q  <= 1'b0;
      cent_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      n_q        <= n_d;
      iter_q     <= iter_d;
      maxi_q     <= maxi_d;
      vld_q      <= vld_d;
      upd_idx_q  <= upd_idx_d;
      div_pend_q <= div_pend_d;
      changed_q  <= changed_d;
      cent_q     <= cent_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_rd_en      = rd_en_q;
  assign mem_rd_addr    = rd_addr_q;
  assign pipe_centroids = cent_q;
  assign pipe_data      = vld_q[0] ? mem_rd_data : '0;
  assign busy           = busy_q;
  assign done           = done_q;
  assign iter_count     = iter_q;
endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// tb_kmeans_iter_ctrl: kmeans_iter_ctrl with a behavioural k2/d3 pipeline and a 1-cycle point RAM.
// Expected run results go to a scoreboard at start and are checked on each done pulse.
module tb_kmeans_iter_ctrl;
  localparam int W      = 16;
  localparam int AW     = 10;
  localparam int IW     = 8;
  localparam int LAT    = 5;
  localparam int BUDGET = 6000;
`ifdef KMEANS_CTRL_CONVERGE_EN
  localparam bit CONV = 1'b1;
`else
  localparam bit CONV = 1'b0;
`endif

  typedef struct {
    logic [6*W-1:0] cent;
    logic [IW-1:0]  iters;
    int             lat;
  } exp_t;

  logic           clk, rst, start, cfg_we, mem_rd_en, pipe_sel, busy, done;
  logic [AW:0]    n_points;
  logic [IW-1:0]  max_iter, iter_count;
  logic [2:0]     cfg_idx;
  logic [W-1:0]   cfg_data;
  logic [AW-1:0]  mem_rd_addr;
  logic [3*W-1:0] mem_rd_data, pipe_data, pipe_out_data;
  logic [6*W-1:0] pipe_centroids;

  logic [3*W-1:0] ram [0:(1<<AW)-1];
  logic [3*W-1:0] pl_data [0:LAT-1];
  logic           pl_sel  [0:LAT-1];
  exp_t           sb [$];
  int             total = 0;
  int             bad = 0;

  kmeans_iter_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n_points(n_points), .max_iter(max_iter),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .pipe_centroids(pipe_centroids), .pipe_data(pipe_data), .pipe_sel(pipe_sel),
    .pipe_out_data(pipe_out_data), .busy(busy), .done(done), .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit nearest(input logic [3*W-1:0] p, input logic [6*W-1:0] c);
    longint d0, d1, a, b0, b1;
    d0 = 0;
    d1 = 0;
    for (int d = 0; d < 3; d++) begin
      a  = {48'd0, p[d*W +: W]};
      b0 = {48'd0, c[d*W +: W]};
      b1 = {48'd0, c[(3+d)*W +: W]};
      d0 += (a - b0) * (a - b0);
      d1 += (a - b1) * (a - b1);
    end
    return d1 < d0;
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  always @(posedge clk) begin
    pl_data[0] <= pipe_data;
    pl_sel[0]  <= nearest(pipe_data, pipe_centroids);
    for (int i = 1; i < LAT; i++) begin
      pl_data[i] <= pl_data[i-1];
      pl_sel[i]  <= pl_sel[i-1];
    end
  end
  assign pipe_out_data = pl_data[LAT-1];
  assign pipe_sel      = pl_sel[LAT-1];

  function automatic logic [6*W-1:0] pack6(input int a0, a1, a2, b0, b1, b2);
    return {W'(b2), W'(b1), W'(b0), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic logic [3*W-1:0] pt(input int x, y, z);
    return {W'(z), W'(y), W'(x)};
  endfunction

  function automatic exp_t ref_kmeans(input int n, input int mi, input logic [6*W-1:0] c_init);
    exp_t e;
    logic [6*W-1:0] c;
    logic [3*W-1:0] w;
    logic [W-1:0]   q;
    longint         sum [6];
    int             cnt [2];
    int             it;
    bit             chg, sel;
    c  = c_init;
    it = 0;
    while (it < mi) begin
      for (int i = 0; i < 6; i++) sum[i] = 0;
      cnt[0] = 0;
      cnt[1] = 0;
      for (int p = 0; p < n; p++) begin
        w   = ram[p];
        sel = nearest(w, c);
        cnt[int'(sel)]++;
        for (int d = 0; d < 3; d++) sum[int'(sel)*3 + d] += longint'({48'd0, w[d*W +: W]});
      end
      chg = 1'b0;
      for (int i = 0; i < 6; i++) begin
        if (cnt[i/3] > 0) begin
          q = W'(sum[i] / longint'(cnt[i/3]));
          if (q != c[i*W +: W]) chg = 1'b1;
          c[i*W +: W] = q;
        end
      end
      it++;
      if (CONV && !chg) break;
    end
    e.cent  = c;
    e.iters = IW'(it);
    e.lat   = (mi == 0) ? 1 : -1;
    return e;
  endfunction

  task automatic cfg_write(input int idx, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_idx  = 3'(idx);
    cfg_data = W'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic set_centroids(input logic [6*W-1:0] c);
    for (int i = 0; i < 6; i++) cfg_write(i, int'(c[i*W +: W]));
  endtask

  task automatic load_test3();
    ram[0] = pt(1, 1, 1);
    ram[1] = pt(3, 3, 3);
    ram[2] = pt(98, 98, 98);
    ram[3] = pt(102, 102, 102);
  endtask

  task automatic push(input logic [6*W-1:0] c, input int it, input int lat);
    exp_t e;
    e.cent  = c;
    e.iters = IW'(it);
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // One run: start pulse (optionally with a same-cycle cfg write), optional pokes while busy, done check.
  task automatic run_job(input int n, input int mi, input bit cfg_at_start, input bit poke);
    exp_t e;
    int   lat;
    bit   seen, busy_seen, dbl;
    @(negedge clk);
    n_points = (AW+1)'(n);
    max_iter = IW'(mi);
    start    = 1'b1;
    if (cfg_at_start) begin
      cfg_we   = 1'b1;
      cfg_idx  = 3'd5;
      cfg_data = W'(100);
    end
    @(negedge clk);
    start     = 1'b0;
    cfg_we    = 1'b0;
    lat       = 1;
    seen      = 1'b0;
    busy_seen = 1'b0;
    while (!seen && lat < BUDGET) begin
      if (busy) busy_seen = 1'b1;
      if (done) seen = 1'b1;
      else begin
        if (poke && lat == 3) begin
          start    = 1'b1;
          cfg_we   = 1'b1;
          cfg_idx  = 3'd0;
          cfg_data = W'(999);
        end else begin
          start  = 1'b0;
          cfg_we = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: got empty queue want an entry");
    end else begin
      e = sb.pop_front();
      if (!seen) begin
        bad++;
        $display("FAIL done_timeout: got no done in %0d cycles want done", BUDGET);
      end else begin
        if (pipe_centroids !== e.cent) begin
          bad++;
          $display("FAIL centroids: got %h want %h", pipe_centroids, e.cent);
        end
        total++;
        if (iter_count !== e.iters) begin
          bad++;
          $display("FAIL iter_count: got %0d want %0d", iter_count, e.iters);
        end
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL busy_at_done: got %b want 0", busy);
        end
        total++;
        if (busy_seen !== (mi != 0)) begin
          bad++;
          $display("FAIL busy_during_run: got %b want %b", busy_seen, (mi != 0));
        end
        if (e.lat >= 0) begin
          total++;
          if (lat !== e.lat) begin
            bad++;
            $display("FAIL done_latency: got %0d want %0d", lat, e.lat);
          end
        end
      end
    end
    dbl = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dbl = 1'b1;
    end
    total++;
    if (dbl !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got extra done want single pulse");
    end
  endtask

  task automatic test_reset();
    #1;
    total += 7;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %b want 0", mem_rd_en); end
    if (mem_rd_addr !== '0) begin bad++; $display("FAIL rst_rd_addr: got %0d want 0", mem_rd_addr); end
    if (iter_count !== '0) begin bad++; $display("FAIL rst_iter: got %0d want 0", iter_count); end
    if (pipe_data !== '0) begin bad++; $display("FAIL rst_pipe_data: got %h want 0", pipe_data); end
    if (pipe_centroids !== '0) begin bad++; $display("FAIL rst_cent: got %h want 0", pipe_centroids); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    int wait_cnt;
    load_test3();
    set_centroids(pack6(0, 0, 0, 100, 100, 100));
    @(negedge clk);
    n_points = 11'd4;
    max_iter = 8'd1;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_cnt = 0;
    while (mem_rd_en !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    total++;
    if (mem_rd_en !== 1'b1) begin
      bad++;
      $display("FAIL stream_start: got rd_en %b want 1", mem_rd_en);
    end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
    if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_en: got %b want 0", mem_rd_en); end
    if (pipe_centroids !== '0) begin bad++; $display("FAIL mid_rst_cent: got %h want 0", pipe_centroids); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_empty_pass();
    set_centroids(pack6(0, 0, 0, 100, 100, 100));
    push(pack6(0, 0, 0, 100, 100, 100), 1, -1);
    run_job(0, 1, 1'b0, 1'b0);
  endtask

  task automatic test_single_pass();
    load_test3();
    set_centroids(pack6(0, 0, 0, 100, 100, 5000));
    push(pack6(2, 2, 2, 100, 100, 100), 1, -1);
    run_job(4, 1, 1'b1, 1'b0);
  endtask

  task automatic test_empty_cluster();
    set_centroids(pack6(0, 0, 0, 1000, 1000, 1000));
    push(pack6(51, 51, 51, 1000, 1000, 1000), 1, -1);
    run_job(4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_converge();
    set_centroids(pack6(0, 0, 0, 100, 100, 100));
    push(pack6(2, 2, 2, 100, 100, 100), CONV ? 2 : 10, -1);
    run_job(4, 10, 1'b0, 1'b0);
  endtask

  task automatic test_busy_ignored();
    set_centroids(pack6(0, 0, 0, 100, 100, 100));
    push(pack6(2, 2, 2, 100, 100, 100), 1, -1);
    run_job(4, 1, 1'b0, 1'b1);
    cfg_write(6, 777);
    cfg_write(7, 888);
    #1;
    total++;
    if (pipe_centroids !== pack6(2, 2, 2, 100, 100, 100)) begin
      bad++;
      $display("FAIL cfg_idx_ignored: got %h want %h", pipe_centroids, pack6(2, 2, 2, 100, 100, 100));
    end
    push(pack6(2, 2, 2, 100, 100, 100), 0, 1);
    run_job(4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [6*W-1:0] c;
    int n, mi;
    for (int r = 0; r < 3; r++) begin
      n  = $urandom_range(1, 12);
      mi = $urandom_range(1, 4);
      for (int p = 0; p < n; p++)
        ram[p] = pt($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 300));
      for (int i = 0; i < 6; i++) c[i*W +: W] = W'($urandom_range(0, 300));
      set_centroids(c);
      sb.push_back(ref_kmeans(n, mi, c));
      run_job(n, mi, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    cfg_we   = 1'b0;
    cfg_idx  = '0;
    cfg_data = '0;
    n_points = '0;
    max_iter = '0;
    test_reset();
    test_reset_mid_stream();
    test_empty_pass();
    test_single_pass();
    test_empty_cluster();
    test_converge();
    test_busy_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
